// File: rtl/lsu.sv
// Load/store unit: one CPU request at a time is checked, driven onto a 2 KiB memory
// window for a single cycle, and answered with a one-cycle response pulse.
module lsu #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic        mem_chip_select,
    output logic        mem_output_enable,
    output logic [3:0]  mem_write_enable,
    output logic [10:0] mem_addr,
    input  logic [31:0] mem_read_data,
    output logic [31:0] mem_write_data
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state;
    logic [1:0]  lane;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic        write_q;
    logic        fault;
    logic [3:0]  strobe;
    logic [31:0] lane_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;

    assign req_ready = (state == IDLE) && !rst;

    always_comb begin
        fault = (req_size == 2'b11)
             || (req_size == 2'b01 && req_addr[0])
             || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
             || (req_addr[31:11] != BASE_ADDR[31:11]);
    end

    // Store data is replicated across lanes so the strobes alone pick the bytes written.
    always_comb begin
        strobe    = 4'b1111;
        lane_data = req_wdata;
        case (req_size)
            2'b00: begin
                strobe    = 4'b0001 << req_addr[1:0];
                lane_data = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                strobe    = req_addr[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{req_wdata[15:0]}};
            end
            default: begin
                strobe    = 4'b1111;
                lane_data = req_wdata;
            end
        endcase
    end

    always_comb begin
        load_byte = mem_read_data[7:0];
        case (lane)
            2'd0: load_byte = mem_read_data[7:0];
            2'd1: load_byte = mem_read_data[15:8];
            2'd2: load_byte = mem_read_data[23:16];
            2'd3: load_byte = mem_read_data[31:24];
            default: load_byte = mem_read_data[7:0];
        endcase
        load_half = lane[1] ? mem_read_data[31:16] : mem_read_data[15:0];
        case (size_q)
            2'b00:   load_data = {{24{~unsigned_q & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{~unsigned_q & load_half[15]}}, load_half};
            default: load_data = mem_read_data;
        endcase
    end

    // Memory strobes are set at acceptance so they are live only during ACCESS.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            lane              <= 2'b00;
            size_q            <= 2'b00;
            unsigned_q        <= 1'b0;
            write_q           <= 1'b0;
            resp_valid        <= 1'b0;
            resp_fault        <= 1'b0;
            resp_rdata        <= 32'h0;
            mem_chip_select   <= 1'b0;
            mem_output_enable <= 1'b0;
            mem_write_enable  <= 4'b0000;
            mem_addr          <= 11'h0;
            mem_write_data    <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        lane       <= req_addr[1:0];
                        size_q     <= req_size;
                        unsigned_q <= req_unsigned;
                        write_q    <= req_write;
                        if (fault) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_fault <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            state             <= ACCESS;
                            mem_chip_select   <= 1'b1;
                            mem_output_enable <= !req_write;
                            mem_write_enable  <= req_write ? strobe : 4'b0000;
                            mem_addr          <= {req_addr[10:2], 2'b00};
                            mem_write_data    <= req_write ? lane_data : 32'h0;
                        end
                    end
                end
                ACCESS: begin
                    state             <= RESP;
                    mem_chip_select   <= 1'b0;
                    mem_output_enable <= 1'b0;
                    mem_write_enable  <= 4'b0000;
                    mem_addr          <= 11'h0;
                    mem_write_data    <= 32'h0;
                    resp_valid        <= 1'b1;
                    resp_fault        <= 1'b0;
                    resp_rdata        <= write_q ? 32'h0 : load_data;
                end
                RESP: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_rdata <= 32'h0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: a byte-level reference model schedules the expected
// outputs per clock, and one compare process checks the DUT against it every cycle.
module tb_lsu;

    localparam int MAXE = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic        mem_chip_select;
    logic        mem_output_enable;
    logic [3:0]  mem_write_enable;
    logic [10:0] mem_addr;
    logic [31:0] mem_read_data;
    logic [31:0] mem_write_data;

    always #5 clk = ~clk;

    lsu #(.BASE_ADDR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_chip_select(mem_chip_select), .mem_output_enable(mem_output_enable),
        .mem_write_enable(mem_write_enable), .mem_addr(mem_addr),
        .mem_read_data(mem_read_data), .mem_write_data(mem_write_data)
    );

    // Memory attached to the DUT, and the model's own view of the same bytes
    logic [7:0] mem [2048];
    logic [7:0] ref_mem [2048];
    bit mem_init = 1'b1;

    assign mem_read_data = {mem[{mem_addr[10:2], 2'd3}], mem[{mem_addr[10:2], 2'd2}],
                            mem[{mem_addr[10:2], 2'd1}], mem[{mem_addr[10:2], 2'd0}]};

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 2048; i++) mem[i] <= 8'((i * 37) ^ 90);
        end else if (mem_chip_select) begin
            for (int n = 0; n < 4; n++)
                if (mem_write_enable[n])
                    mem[{mem_addr[10:2], 2'(n)}] <= mem_write_data[8*n +: 8];
        end
    end

    // Expected outputs, indexed by the clock edge after which they are visible
    logic        e_cs   [MAXE];
    logic        e_oe   [MAXE];
    logic [3:0]  e_we   [MAXE];
    logic [10:0] e_addr [MAXE];
    logic [31:0] e_wd   [MAXE];
    logic        e_rv   [MAXE];
    logic        e_rf   [MAXE];
    logic [31:0] e_rd   [MAXE];

    int edge_cnt  = 0;
    int next_free = 0;
    int total     = 0;
    int bad       = 0;
    bit check_en  = 1'b0;
    bit model_on  = 1'b0;

    bit          pend = 1'b0;
    int          pend_edge;
    int          pend_base;
    logic [3:0]  pend_we;
    logic [31:0] pend_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s at edge %0d: got %h, expected %h", name, edge_cnt, act, exp);
        end
    endtask

    task automatic clear_model(input int from);
        for (int i = from; i < MAXE; i++) begin
            e_cs[i] = 0; e_oe[i] = 0; e_we[i] = 0; e_addr[i] = 0;
            e_wd[i] = 0; e_rv[i] = 0; e_rf[i] = 0; e_rd[i] = 0;
        end
    endtask

    // Reference model: decides acceptance from request spacing and schedules results
    task automatic model_edge();
        int k;
        int nb;
        int off;
        int base;
        bit flt;
        logic [31:0] v;
        logic [31:0] wd;
        logic [3:0]  we;
        k = edge_cnt;
        if (pend && pend_edge == k) begin
            for (int n = 0; n < 4; n++)
                if (pend_we[n]) ref_mem[pend_base + n] = pend_data[8*n +: 8];
            pend = 1'b0;
        end
        if (req_valid && k >= next_free) begin
            nb   = 1 << req_size;
            off  = int'(req_addr[1:0]);
            base = int'(req_addr[10:2]) * 4;
            flt  = (req_size == 2'd3) || (off % nb != 0) || (req_addr[31:11] != 21'd0);
            if (flt) begin
                e_rv[k] = 1; e_rf[k] = 1; e_rd[k] = 0;
                next_free = k + 2;
            end else begin
                e_cs[k]   = 1;
                e_addr[k] = 11'(base);
                if (req_write) begin
                    wd = 0; we = 0;
                    for (int n = 0; n < 4; n++) begin
                        wd[8*n +: 8] = req_wdata[8*(n % nb) +: 8];
                        if (n >= off && n < off + nb) we[n] = 1'b1;
                    end
                    e_oe[k] = 0; e_we[k] = we; e_wd[k] = wd;
                    pend = 1'b1; pend_edge = k + 1; pend_base = base;
                    pend_we = we; pend_data = wd;
                    e_rd[k+1] = 0;
                end else begin
                    v = 0;
                    for (int j = 0; j < nb; j++)
                        v = v | (32'(ref_mem[base + off + j]) << (8 * j));
                    if (!req_unsigned && nb < 4 && v[8*nb-1])
                        v = v | (32'hFFFF_FFFF << (8 * nb));
                    e_oe[k] = 1; e_we[k] = 0; e_wd[k] = 0;
                    e_rd[k+1] = v;
                end
                e_rv[k+1] = 1; e_rf[k+1] = 0;
                next_free = k + 3;
            end
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            int k;
            k = edge_cnt;
            check("req_ready", 32'(req_ready), 32'(k + 1 >= next_free));
            check("mem_chip_select", 32'(mem_chip_select), 32'(e_cs[k]));
            check("mem_output_enable", 32'(mem_output_enable), 32'(e_oe[k]));
            check("mem_write_enable", 32'(mem_write_enable), 32'(e_we[k]));
            check("mem_addr", 32'(mem_addr), 32'(e_addr[k]));
            if (!(e_cs[k] && e_oe[k]))
                check("mem_write_data", mem_write_data, e_wd[k]);
            check("resp_valid", 32'(resp_valid), 32'(e_rv[k]));
            check("resp_fault", 32'(resp_fault), 32'(e_rf[k]));
            check("resp_rdata", resp_rdata, e_rd[k]);
        end
    end

    task automatic tick();
        @(posedge clk);
        edge_cnt++;
        if (model_on && !rst) model_edge();
        @(negedge clk);
        #1;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        #1;
        check("req_ready after reset release", 32'(req_ready), 32'd1);
        pend = 1'b0;
        clear_model(edge_cnt);
        next_free = edge_cnt + 1;
        model_on  = 1'b1;
        check_en  = 1'b1;
    endtask

    task automatic apply_stimulus(input logic w, input logic [1:0] sz, input logic u,
                                  input logic [31:0] a, input logic [31:0] wd);
        bit rdy;
        bit accepted;
        req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        accepted = 1'b0;
        for (int i = 0; i < 8 && !accepted; i++) begin
            rdy = req_ready;
            tick();
            accepted = rdy;
        end
        req_valid = 1'b0;
        check("accept within budget", 32'(accepted), 32'd1);
    endtask

    // One directed transaction with literal expectations, ending with the DUT idle
    task automatic check_output(input string nm, input logic w, input logic [1:0] sz,
                                input logic u, input logic [31:0] a, input logic [31:0] wd,
                                input logic xflt, input logic [3:0] xwe,
                                input logic [10:0] xaddr, input logic [31:0] xwd,
                                input logic [31:0] xrd);
        apply_stimulus(w, sz, u, a, wd);
        if (xflt) begin
            check({nm, " fault resp_valid"}, 32'(resp_valid), 32'd1);
            check({nm, " fault flag"}, 32'(resp_fault), 32'd1);
            check({nm, " fault rdata"}, resp_rdata, 32'd0);
            check({nm, " fault strobes"}, 32'({mem_chip_select, mem_write_enable}), 32'd0);
            tick();
        end else begin
            check({nm, " strobe"}, 32'(mem_write_enable), 32'(xwe));
            check({nm, " mem_addr"}, 32'(mem_addr), 32'(xaddr));
            if (w) check({nm, " mem_write_data"}, mem_write_data, xwd);
            tick();
            check({nm, " resp_valid"}, 32'(resp_valid), 32'd1);
            check({nm, " resp_fault"}, 32'(resp_fault), 32'd0);
            check({nm, " resp_rdata"}, resp_rdata, xrd);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        logic [9:0]  acc_mask;
        int resp_cnt;
        int r;

        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'((i * 37) ^ 90);
        clear_model(0);
        req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0;
        req_addr = 0; req_wdata = 0;
        rst = 1'b1;
        #1;
        check("reset req_ready", 32'(req_ready), 32'd0);
        tick(); tick();
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset strobes", 32'({mem_chip_select, mem_output_enable, mem_write_enable}), 32'd0);
        mem_init = 1'b0;
        release_reset();

        $display("[TB] directed transactions");
        check_output("SW", 1, 2'b10, 0, 32'h004, 32'hDEADBEEF, 0, 4'b1111, 11'h004, 32'hDEADBEEF, 32'h0);
        check_output("LW", 0, 2'b10, 0, 32'h004, 32'h0, 0, 4'b0000, 11'h004, 32'h0, 32'hDEADBEEF);
        check_output("SB", 1, 2'b00, 0, 32'h013, 32'h000000A5, 0, 4'b1000, 11'h010, 32'hA5A5A5A5, 32'h0);
        check_output("LB", 0, 2'b00, 0, 32'h013, 32'h0, 0, 4'b0000, 11'h010, 32'h0, 32'hFFFFFFA5);
        check_output("LBU", 0, 2'b00, 1, 32'h013, 32'h0, 0, 4'b0000, 11'h010, 32'h0, 32'h000000A5);
        check_output("SH", 1, 2'b01, 0, 32'h022, 32'h00008001, 0, 4'b1100, 11'h020, 32'h80018001, 32'h0);
        check_output("LH", 0, 2'b01, 0, 32'h022, 32'h0, 0, 4'b0000, 11'h020, 32'h0, 32'hFFFF8001);
        check_output("LHU", 0, 2'b01, 1, 32'h022, 32'h0, 0, 4'b0000, 11'h020, 32'h0, 32'h00008001);
        check_output("LW misaligned", 0, 2'b10, 0, 32'h006, 32'h0, 1, 4'b0000, 11'h0, 32'h0, 32'h0);
        check_output("LH misaligned", 0, 2'b01, 0, 32'h001, 32'h0, 1, 4'b0000, 11'h0, 32'h0, 32'h0);
        check_output("illegal size", 0, 2'b11, 0, 32'h000, 32'h0, 1, 4'b0000, 11'h0, 32'h0, 32'h0);
        check_output("LW out of window", 0, 2'b10, 0, 32'h800, 32'h0, 1, 4'b0000, 11'h0, 32'h0, 32'h0);
        check_output("SW out of window", 1, 2'b10, 0, 32'h1000_0000, 32'h12345678, 1, 4'b0000, 11'h0, 32'h0, 32'h0);

        $display("[TB] reset during store access");
        apply_stimulus(1, 2'b10, 0, 32'h100, 32'hCAFEF00D);
        check("abort strobe before reset", 32'(mem_write_enable), 32'hF);
        check_en = 1'b0;
        rst = 1'b1;
        #1;
        check("abort strobe drops with reset", 32'(mem_write_enable), 32'd0);
        check("abort chip select drops", 32'(mem_chip_select), 32'd0);
        check("abort req_ready low in reset", 32'(req_ready), 32'd0);
        tick();
        check("abort no resp_valid", 32'(resp_valid), 32'd0);
        release_reset();
        check_output("LW after abort", 0, 2'b10, 0, 32'h100, 32'h0, 0, 4'b0000, 11'h100, 32'h0,
                     {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]});

        $display("[TB] held request burst");
        acc_mask = 0;
        resp_cnt = 0;
        req_write = 0; req_size = 2'b10; req_unsigned = 0; req_addr = 32'h040; req_valid = 1;
        for (int c = 0; c < 10; c++) begin
            acc_mask[c] = req_ready;
            tick();
            if (resp_valid) resp_cnt++;
        end
        req_valid = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (resp_valid) resp_cnt++;
        end
        check("burst accept cycles", 32'(acc_mask), 32'(10'b10_0100_1001));
        check("burst resp count", 32'(resp_cnt), 32'd4);

        $display("[TB] random traffic");
        for (int it = 0; it < 1500; it++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            r  = $urandom_range(0, 99);
            if (r < 8)
                a = {21'($urandom_range(1, 2097151)), 11'($urandom_range(0, 2047))};
            else if (r < 50)
                a = 32'($urandom_range(0, 63));
            else
                a = 32'($urandom_range(0, 2047));
            if (r >= 8 && r < 80 && sz != 2'd3)
                a = a & ~((32'd1 << sz) - 32'd1);
            req_valid    = ($urandom_range(0, 9) < 7);
            req_write    = 1'($urandom_range(0, 1));
            req_size     = sz;
            req_unsigned = 1'($urandom_range(0, 1));
            req_addr     = a;
            req_wdata    = $urandom;
            tick();
        end
        req_valid = 0;
        tick(); tick(); tick();

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, SHALL give the 2 KiB-aligned byte base of the attached memory window.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req_valid  in  1  CPU load/store request present.
REQ-005 req_ready  out  1  LSU can accept a request this cycle.
REQ-006 req_write  in  1  1 = store, 0 = load.
REQ-007 req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 req_addr  in  32  byte address.
REQ-010 req_wdata  in  32  store data, right-justified.
REQ-011 resp_valid  out  1  one-cycle completion pulse.
REQ-012 resp_rdata  out  32  extended load data; 0 for stores and faults.
REQ-013 resp_fault  out  1  request rejected (misaligned, out of window, illegal size); valid with resp_valid.
REQ-014 mem_chip_select  out  1  memory select.
REQ-015 mem_output_enable  out  1  memory read enable.
REQ-016 mem_write_enable  out  4  per-byte-lane write strobes, bit n = bits [8n+7:8n].
REQ-017 mem_addr  out  11  memory byte address.
REQ-018 mem_read_data  in  32  combinational memory read word.
REQ-019 mem_write_data  out  32  lane-positioned store data.

Function
REQ-020 States SHALL be IDLE, ACCESS, RESP; req_ready SHALL be 1 exactly when state is IDLE and rst is low.
REQ-021 A request SHALL be accepted on a rising edge with req_valid && req_ready; req_write, req_size, req_unsigned, req_addr, req_wdata SHALL be registered at that edge and ignored afterwards.
REQ-022 Fault on acceptance: req_size==11, or size 01 with addr[0]==1, or size 10 with addr[1:0]!=0, or addr[31:11]!=BASE_ADDR[31:11].
REQ-023 A faulting request SHALL go IDLE->RESP with no memory strobe; resp_valid=1, resp_fault=1, resp_rdata=0 during the following cycle.
REQ-024 A legal request SHALL go IDLE->ACCESS->RESP->IDLE: strobes during the cycle after acceptance, resp_valid during the next, req_ready again the cycle after.
REQ-025 During ACCESS only: mem_chip_select=1; mem_addr = {addr[10:2], 2'b00} (lane selected via strobes only, never via mem_addr[1:0]).
REQ-026 Load ACCESS: mem_output_enable=1, mem_write_enable=0000; mem_read_data SHALL be captured at the ACCESS-ending edge.
REQ-027 Store ACCESS: mem_output_enable=0; byte: strobe 1<<addr[1:0], data {4{wdata[7:0]}}; half: strobe 0011 (addr[1]=0) or 1100 (addr[1]=1), data {2{wdata[15:0]}}; word: 1111, wdata.
REQ-028 Load extraction: byte = lane addr[1:0]; half = bits [15:0] or [31:16] by addr[1]; word = full; byte/half extended per req_unsigned to 32 bits.
REQ-029 Outside ACCESS, mem_chip_select, mem_output_enable, mem_write_enable SHALL be 0; mem_addr and mem_write_data SHALL be 0.
REQ-030 resp_valid SHALL be a single-cycle pulse with no backpressure; resp_rdata and resp_fault SHALL be 0 whenever resp_valid=0.
REQ-031 Strobes SHALL be registered outputs (glitch-free) and write strobes SHALL be asserted for exactly one clock per store.
REQ-032 Back-to-back requests SHALL be accepted at most one per 3 cycles (legal) or 2 cycles (fault); req_valid held high across RESP SHALL be accepted on the first IDLE edge.

Reset
REQ-033 rst high SHALL immediately force state IDLE and all outputs to 0 (req_ready 0 while rst high, 1 the cycle after release).
REQ-034 rst asserted during ACCESS or RESP SHALL abort the request: strobes drop asynchronously, no resp_valid for it.

Verification
REQ-035 SW addr 0x004 data 0xDEADBEEF, then LW 0x004 -> strobe 1111 one cycle, mem_addr 0x004; load resp_rdata 0xDEADBEEF, fault 0, resp 2 cycles after accept.
REQ-036 SB addr 0x013 data 0x000000A5 -> strobe 1000, mem_addr 0x010, mem_write_data 0xA5A5A5A5; LB 0x013 -> 0xFFFFFFA5; LBU -> 0x000000A5.
REQ-037 SH addr 0x022 data 0x8001, LH 0x022 -> strobe 1100, rdata 0xFFFF8001; LHU -> 0x00008001.
REQ-038 LW 0x006, LH 0x001, size 11, LW 0x00000800 (BASE 0) -> resp_fault=1, rdata 0, zero strobes, resp the cycle after accept.
REQ-039 rst pulsed during store ACCESS -> mem_write_enable falls to 0 with rst, no resp_valid, req_ready 1 the cycle after release.
REQ-040 req_valid held high for 10 cycles with legal loads -> accepts at cycles 0, 3, 6, 9; exactly one resp_valid per accept.
